// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared defaults and the debounce counter-width check for input blocks.
package input_conditioner_pkg;
  localparam logic DEFAULT_RESET_LEVEL = 1'b0;
  function automatic bit stable_ok(int stable, int cnt_w);
    return stable >= 1 && $clog2(stable + 1) <= cnt_w;
  endfunction
endpackage

// File: rtl/input_conditioner_ch.sv
// input_conditioner_ch: one channel of sync chain, debounce counter, stable level and edge strobes.
module input_conditioner_ch
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W = 16,
  parameter logic RESET_LEVEL = DEFAULT_RESET_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic b,
  output logic b_rise,
  output logic b_fall,
  output logic fire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  if (!stable_ok(STABLE_CYCLES, CNT_W) || SYNC_STAGES < 2) begin : g_bad_params
    $error("input_conditioner_ch: STABLE_CYCLES must be 1..2^CNT_W-1 and SYNC_STAGES >= 2");
  end
  logic [SYNC_STAGES-1:0] s;
  logic [CNT_W-1:0] cnt;
  logic sync;
  assign sync = s[SYNC_STAGES-1];
  assign fire = sync != b && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= {SYNC_STAGES{RESET_LEVEL}};
      b <= RESET_LEVEL;
      cnt <= '0;
      b_rise <= 1'b0;
      b_fall <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], a};
      b_rise <= fire & sync;
      b_fall <= fire & ~sync;
      b <= fire ? sync : b;
      cnt <= (sync == b || fire) ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: multi-channel debouncer with per-channel levels/strobes and a shared any-edge strobe.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W = 16,
  parameter logic RESET_LEVEL = DEFAULT_RESET_LEVEL
) (
  input  logic clk,
  input  logic rst,
  input  logic [CHANNELS-1:0] a,
  output logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] b_rise,
  output logic [CHANNELS-1:0] b_fall,
  output logic b_any
);
  logic [CHANNELS-1:0] fire;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W(CNT_W),
      .RESET_LEVEL(RESET_LEVEL)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .a(a[i]),
      .b(b[i]),
      .b_rise(b_rise[i]),
      .b_fall(b_fall[i]),
      .fire(fire[i])
    );
  end
  // registered from the channels' next-strobe terms so it lines up with b_rise/b_fall
  always_ff @(posedge clk) begin
    b_any <= rst ? 1'b0 : |fire;
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random checks against a window-based debounce model.
module tb_input_conditioner;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int SC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] a = '0;
  logic [CH-1:0] b, b_rise, b_fall;
  logic b_any;
  int passed = 0;
  int total = 0;

  input_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CNT_W(3), .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .b_rise(b_rise), .b_fall(b_fall), .b_any(b_any)
  );

  always #5 clk = ~clk;

  // Model: a reaches the debouncer SS edges late; a level flips once the last SC
  // samples seen since the previous flip/reset all disagree with it.
  logic [CH-1:0] apipe[$];
  bit hist[CH][$];
  logic [CH-1:0] m_b = '0, m_rise = '0, m_fall = '0, m_sync;
  logic m_any = 1'b0;
  bit all_diff;

  initial for (int k = 0; k < SS; k++) apipe.push_back('0);

  always @(posedge clk) begin
    if (rst) begin
      apipe.delete();
      for (int k = 0; k < SS; k++) apipe.push_back('0);
      for (int c = 0; c < CH; c++) hist[c].delete();
      m_b = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      m_sync = apipe.pop_front();
      apipe.push_back(a);
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        hist[c].push_back(m_sync[c]);
        if (hist[c].size() > SC) void'(hist[c].pop_front());
        all_diff = hist[c].size() == SC;
        foreach (hist[c][j]) if (hist[c][j] == m_b[c]) all_diff = 0;
        if (all_diff) begin
          m_b[c] = m_sync[c];
          m_rise[c] = m_sync[c];
          m_fall[c] = ~m_sync[c];
          hist[c].delete();
        end
      end
    end
    m_any = |(m_rise | m_fall);
  end

  task automatic check(string name, logic [CH-1:0] act, logic [CH-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    check("b", b, m_b);
    check("b_rise", b_rise, m_rise);
    check("b_fall", b_fall, m_fall);
    check("b_any", {3'b0, b_any}, {3'b0, m_any});
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    a = 4'hF;
    rst = 1'b1;
    step(3);
    check("rst_b", b, 4'h0);
    check("rst_rise", b_rise, 4'h0);
    rst = 1'b0;
    step(5);
    check("t1_b_pre", b, 4'h0);
    step(1);
    check("t1_b", b, 4'hF);
    check("t1_rise", b_rise, 4'hF);
    check("t1_any", {3'b0, b_any}, 4'h1);
    step(1);
    check("t1_rise_gone", b_rise, 4'h0);
    a = 4'h0;
    step(10);
    check("t2_settle", b, 4'h0);
    a[0] = 1'b1;
    step(5);
    check("t2_b0_pre", {3'b0, b[0]}, 4'h0);
    step(1);
    check("t2_b0", {3'b0, b[0]}, 4'h1);
    check("t2_rise", b_rise, 4'h1);
    check("t2_fall", b_fall, 4'h0);
    step(1);
    check("t2_rise_gone", b_rise, 4'h0);
    a[1] = 1'b1;
    step(3);
    a[1] = 1'b0;
    step(10);
    check("t3_bounce_b1", {3'b0, b[1]}, 4'h0);
    a[1] = 1'b1;
    step(4);
    a[1] = 1'b0;
    step(2);
    check("t3_b1_up", {3'b0, b[1]}, 4'h1);
    check("t3_rise", b_rise, 4'h2);
    step(3);
    check("t3_b1_hold", {3'b0, b[1]}, 4'h1);
    step(1);
    check("t3_b1_down", {3'b0, b[1]}, 4'h0);
    check("t3_fall", b_fall, 4'h2);
    a = 4'h0;
    step(10);
    a = 4'h5;
    step(6);
    check("t4_rise", b_rise, 4'h5);
    check("t4_fall", b_fall, 4'h0);
    check("t4_any", {3'b0, b_any}, 4'h1);
    a = 4'h0;
    step(10);
    a = 4'h4;
    step(4);
    rst = 1'b1;
    step(2);
    check("t5_b2_rst", b, 4'h0);
    rst = 1'b0;
    step(5);
    check("t5_b2_pre", {3'b0, b[2]}, 4'h0);
    step(1);
    check("t5_b2", {3'b0, b[2]}, 4'h1);
    check("t5_rise", b_rise, 4'h4);
    for (int n = 0; n < 10000;) begin
      int hold;
      a = 4'($urandom);
      hold = $urandom_range(1, 8);
      step(hold);
      n += hold;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
